// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } rx_state_t;

   localparam int UART_DATA_BITS = 8;

   // Width needed to hold a fill level of 0..depth inclusive.
   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// CPU-facing receive bus plus the serial input pin of the UART receiver.
interface uart_rx_fifo_if
   import uart_pkg::*;
#(
   parameter int CNT_W = 3
);
   logic                      uart_rxd;
   logic                      rd_en;
   logic                      err_clr;
   logic [UART_DATA_BITS-1:0] rx_data;
   logic                      rx_valid;
   logic [CNT_W-1:0]          rx_count;
   logic                      frame_err;
   logic                      overrun;
   logic                      irq;

   modport master (
      output uart_rxd, rd_en, err_clr,
      input  rx_data, rx_valid, rx_count, frame_err, overrun, irq
   );

   modport slave (
      input  uart_rxd, rd_en, err_clr,
      output rx_data, rx_valid, rx_count, frame_err, overrun, irq
   );
endinterface

// File: rtl/uart_rx_fifo_fifo.sv
// Small first-word-fall-through byte FIFO; the head is held in a register
// so the storage array only ever needs a registered read.
module rx_byte_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   generate
      if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
         $error("rx_byte_fifo: DEPTH must be a power of 2 and >= 2");
      end
   endgenerate

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [WIDTH-1:0] head_reg, head_next;
   logic             do_push, do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(do_pop);
      count_next  = count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
      head_next   = mem[rd_ptr_next];
      // The byte being written this cycle becomes the head when it lands
      // on the slot the read pointer is about to point at.
      if (count_next == '0) begin
         head_next = '0;
      end else if (do_push && (wr_ptr_reg == rd_ptr_next)) begin
         head_next = wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         head_reg   <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_reg + PTR_W'(do_push);
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
         head_reg   <= head_next;
      end
   end

   assign head  = head_reg;
   assign count = count_reg;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: pin synchroniser, mid-bit sampling deframer, FWFT byte
// FIFO, sticky error flags and an interrupt request.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4,
   parameter int CNT_W        = count_width(FIFO_DEPTH)
) (
   input  logic           clk_in,
   input  logic           sys_rstn,
   uart_rx_fifo_if.slave  bus
);
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_MID  = BAUD_W'(CLKS_PER_BIT / 2 - 1);
   localparam int IDX_W = $clog2(UART_DATA_BITS);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

   generate
      if (CLKS_PER_BIT < 4) begin : g_bad_cpb
         $error("uart_rx_fifo: CLKS_PER_BIT must be >= 4");
      end
   endgenerate

   logic                      meta_reg, rxs_reg;
   rx_state_t                 state_reg, state_next;
   logic [BAUD_W-1:0]         baud_reg, baud_next;
   logic [IDX_W-1:0]          idx_reg, idx_next;
   logic [UART_DATA_BITS-1:0] shift_reg, shift_next;
   logic                      push, frame_set, overrun_set;
   logic                      frame_err_reg, overrun_reg;
   logic                      fifo_full, fifo_empty;
   logic [UART_DATA_BITS-1:0] fifo_head;
   logic [CNT_W-1:0]          fifo_count;

   // Line idles high, so the synchroniser resets to 1 to avoid a false start.
   always_ff @(posedge clk_in or posedge sys_rstn) begin
      if (sys_rstn) begin
         meta_reg <= 1'b1;
         rxs_reg  <= 1'b1;
      end else begin
         meta_reg <= bus.uart_rxd;
         rxs_reg  <= meta_reg;
      end
   end

   always_ff @(posedge clk_in or posedge sys_rstn) begin
      if (sys_rstn) begin
         state_reg <= IDLE;
         baud_reg  <= '0;
         idx_reg   <= '0;
         shift_reg <= '0;
      end else begin
         state_reg <= state_next;
         baud_reg  <= baud_next;
         idx_reg   <= idx_next;
         shift_reg <= shift_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      baud_next  = baud_reg + 1'b1;
      idx_next   = idx_reg;
      shift_next = shift_reg;
      push       = 1'b0;
      frame_set  = 1'b0;
      unique case (state_reg)
         IDLE: begin
            baud_next = '0;
            if (!rxs_reg) begin
               state_next = START;
            end
         end
         START: begin
            // A start bit that is high again at its midpoint was a glitch.
            if (baud_reg == BAUD_MID) begin
               baud_next  = '0;
               idx_next   = '0;
               state_next = rxs_reg ? IDLE : DATA;
            end
         end
         DATA: begin
            if (baud_reg == BAUD_LAST) begin
               baud_next           = '0;
               shift_next[idx_reg] = rxs_reg;
               idx_next            = idx_reg + 1'b1;
               if (idx_reg == IDX_LAST) begin
                  state_next = STOP;
               end
            end
         end
         STOP: begin
            if (baud_reg == BAUD_LAST) begin
               baud_next = '0;
               if (rxs_reg) begin
                  push       = 1'b1;
                  state_next = IDLE;
               end else begin
                  frame_set  = 1'b1;
                  state_next = WAIT_IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            baud_next = '0;
            if (rxs_reg) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   rx_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_BITS),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk   (clk_in),
      .rst   (sys_rstn),
      .push  (push),
      .wdata (shift_reg),
      .pop   (bus.rd_en),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // A same-cycle pop frees a slot, so only a push into a full FIFO with no
   // pop loses data.
   assign overrun_set = push && fifo_full && !bus.rd_en;

   // Setting has priority over clearing so a coincident error is never lost.
   always_ff @(posedge clk_in or posedge sys_rstn) begin
      if (sys_rstn) begin
         frame_err_reg <= 1'b0;
         overrun_reg   <= 1'b0;
      end else begin
         frame_err_reg <= frame_set   | (frame_err_reg & ~bus.err_clr);
         overrun_reg   <= overrun_set | (overrun_reg   & ~bus.err_clr);
      end
   end

   assign bus.rx_data   = fifo_head;
   assign bus.rx_valid  = ~fifo_empty;
   assign bus.rx_count  = fifo_count;
   assign bus.frame_err = frame_err_reg;
   assign bus.overrun   = overrun_reg;
   assign bus.irq       = ~fifo_empty | frame_err_reg | overrun_reg;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Serial receive front end of the SoC UART device; consumes `uart_rxd` straight off the board pin and feeds received bytes to the CPU bus bridge.
- Contains a synchroniser, a mid-bit-sampling 8N1 deframer and a small first-word-fall-through (FWFT) byte FIFO.
- Also provides sticky error flags and an interrupt request for the CP0/interrupt logic.

Parameters:
- CLKS_PER_BIT, 16, clk_in cycles per UART bit. Must be >= 4; elaboration fails otherwise.
- FIFO_DEPTH, 4, receive FIFO entries. Power of 2, >= 2.
- CNT_W, $clog2(FIFO_DEPTH+1), width of the `rx_count` output.

Ports:
- clk_in  input  1  system clock.
- sys_rstn  input  1  asynchronous reset, active-high (1 = reset; port name kept as in the codebase).
- uart_rxd  input  1  asynchronous serial line; idles high.
- rd_en  input  1  pop the FIFO head this cycle.
- err_clr  input  1  clear `frame_err` and `overrun`.
- rx_data  output  8  FIFO head byte. Valid only while `rx_valid` is 1.
- rx_valid  output  1  FIFO non-empty.
- rx_count  output  CNT_W  number of bytes currently held.
- frame_err  output  1  sticky: stop bit sampled low.
- overrun  output  1  sticky: byte dropped because the FIFO was full.
- irq  output  1  equals rx_valid | frame_err | overrun.

Behaviour:
- Reset (async assert, sync release):
  - Synchroniser flops reset to 1.
  - FSM goes to IDLE; bit counter and baud counter reset to 0.
  - FIFO is emptied.
  - All outputs are 0, except `rx_data`, which is 0 while empty.
  - Reset mid-frame discards the partial byte. No flag is set.
- Synchroniser: 2 flops on `uart_rxd`. The FSM sees only the synchronised value `rxs`.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: `rxs` = 0 → START, baud counter cleared.
  - START: when the baud counter reaches CLKS_PER_BIT/2 - 1 (mid start bit), sample `rxs`.
    - 0 → DATA, baud counter cleared, bit index 0.
    - 1 → IDLE (glitch rejected).
  - DATA: each time the baud counter reaches CLKS_PER_BIT - 1, sample `rxs` into shift bit[index], LSB first.
    - After index 7 → STOP.
  - STOP: at CLKS_PER_BIT - 1, sample `rxs`.
    - 1 → push the byte and go to IDLE.
    - 0 → set `frame_err`, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rxs` = 1, then → IDLE. No new frame can start while the line is held low (break).
- Latency: the push occurs on the clock edge at mid stop bit. `rx_valid` rises the cycle after that edge. The 2-cycle synchroniser delay is included in the sample timing.
- FIFO behaviour:
  - FWFT: `rx_data` is the registered head entry, updated the cycle after a push into an empty FIFO or after a pop.
  - Pointers wrap modulo FIFO_DEPTH.
  - `rx_count` width CNT_W covers 0..FIFO_DEPTH.
- Boundary conditions:
  - `rd_en` while empty: ignored; no pointer movement, no error.
  - Push while full without a same-cycle pop: byte dropped, `overrun` set. The existing contents and head are unchanged.
  - Push and pop in the same cycle, FIFO full: both occur; count stays FIFO_DEPTH; no overrun.
  - Push and pop in the same cycle, FIFO empty: the push occurs; the pop is ignored; count becomes 1.
  - Push and pop in the same cycle, other fill levels: count unchanged; the head advances.
  - `err_clr` in the same cycle as a new error event: the set wins, and the flag stays 1.
- Back-to-back frames: after the stop sample, IDLE accepts a falling edge from the next cycle onward. Consecutive frames with a 1-bit stop are received with no gap.

Decomposition:
- Shared package `uart_pkg`:
  - FSM state enum: IDLE, START, DATA, STOP, WAIT_IDLE.
  - Constant UART_DATA_BITS = 8.
  - Function for CNT_W calculation.
- One sub-module: `rx_byte_fifo` (parameters DEPTH and WIDTH=8; push/pop/full/empty/count; FWFT head). The deframer FSM stays in the top.

Test Plan (CLKS_PER_BIT=16, FIFO_DEPTH=4):
1. Drive 8N1 frame 0xA5 (start 0; bits 1,0,1,0,0,1,0,1; stop 1) → `rx_valid` = 1 at most 10*16 + 3 cycles after the start edge; `rx_data` = 0xA5; `rx_count` = 1. Pulse `rd_en` → `rx_valid` = 0, `rx_count` = 0.
2. Low glitch of 3 cycles on an idle line → no push; FSM back in IDLE; `rx_count` stays 0; no flags set.
3. Frame 0x3C with stop bit 0, line held low for 40 cycles, then frame 0x11 → `frame_err` = 1, only 0x11 in the FIFO (count 1). Pulse `err_clr` → `frame_err` = 0.
4. Send 0x01, 0x02, 0x03, 0x04, 0x05 back-to-back with no reads → count 4, `overrun` = 1, `irq` = 1. Reads return 0x01..0x04 in order, then `rx_valid` = 0.
5. FIFO full (4 bytes); assert `rd_en` on the exact stop-sample cycle of a 5th frame 0x99 → no overrun; count stays 4; read order 0x02, 0x03, 0x04, 0x99.
6. Assert `sys_rstn` = 1 mid-DATA of frame 0x7E with 2 bytes queued → all outputs 0 asynchronously. After release, frame 0x42 is received correctly as the sole entry.
